fp_operand_tx: RTL

FP_OPERAND_TX -- requirements
Module: fp_operand_tx

---
 rtl/fp_operand_tx.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/fp_operand_tx.sv
// Serial operand transmitter for a bit-serial FP adder.
// Streams {op_a, op_b} MSB first, then waits for done or timeout.
module fp_operand_tx #(
    parameter int LEAD_CYC = 1,
    parameter int WAIT_MAX = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        go,
    output logic        inpab,
    input  logic        done,
    input  logic        over,
    input  logic        under,
    output logic        complete,
    output logic        exc_over,
    output logic        exc_under,
    output logic        timeout
);

    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        SEND,
        WAIT
    } state_t;

    localparam logic [3:0] LEAD_LAST = 4'(LEAD_CYC - 1);
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t      state_q, state_d;
    logic [63:0] opnd_q, opnd_d;
    logic [3:0]  lead_q, lead_d;
    logic [5:0]  bit_q, bit_d;
    logic [7:0]  wait_q, wait_d;
    logic        go_q, go_d;
    logic        inpab_q, inpab_d;
    logic        busy_q, busy_d;
    logic        cmp_q, cmp_d;
    logic        ovr_q, ovr_d;
    logic        und_q, und_d;
    logic        tmo_q, tmo_d;
    logic [5:0]  nb;

    always_comb begin
        state_d = state_q;
        opnd_d  = opnd_q;
        lead_d  = lead_q;
        bit_d   = bit_q;
        wait_d  = wait_q;
        inpab_d = inpab_q;
        cmp_d   = 1'b0;
        ovr_d   = ovr_q;
        und_d   = und_q;
        tmo_d   = tmo_q;
        nb      = bit_q + 6'd1;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    opnd_d  = {op_a, op_b};
                    ovr_d   = 1'b0;
                    und_d   = 1'b0;
                    tmo_d   = 1'b0;
                    lead_d  = 4'd0;
                    state_d = LEAD;
                end
            end
            LEAD: begin
                if (lead_q == LEAD_LAST) begin
                    state_d = SEND;
                    bit_d   = 6'd0;
                    inpab_d = opnd_q[63];
                end else begin
                    lead_d = lead_q + 4'd1;
                end
            end
            SEND: begin
                if (bit_q == 6'd63) begin
                    state_d = WAIT;
                    inpab_d = 1'b0;
                    wait_d  = 8'd0;
                end else begin
                    bit_d   = nb;
                    // stream index counts down from bit 63 of {op_a, op_b}
                    inpab_d = opnd_q[~nb];
                end
            end
            WAIT: begin
                if (done) begin
                    ovr_d   = over;
                    und_d   = under;
                    cmp_d   = 1'b1;
                    state_d = IDLE;
                end else if (wait_q == WAIT_LAST) begin
                    tmo_d   = 1'b1;
                    cmp_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        go_d   = (state_d == IDLE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            opnd_q  <= 64'd0;
            lead_q  <= 4'd0;
            bit_q   <= 6'd0;
            wait_q  <= 8'd0;
            go_q    <= 1'b1;
            inpab_q <= 1'b0;
            busy_q  <= 1'b0;
            cmp_q   <= 1'b0;
            ovr_q   <= 1'b0;
            und_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opnd_q  <= opnd_d;
            lead_q  <= lead_d;
            bit_q   <= bit_d;
            wait_q  <= wait_d;
            go_q    <= go_d;
            inpab_q <= inpab_d;
            busy_q  <= busy_d;
            cmp_q   <= cmp_d;
            ovr_q   <= ovr_d;
            und_q   <= und_d;
            tmo_q   <= tmo_d;
        end
    end

    assign busy      = busy_q;
    assign go        = go_q;
    assign inpab     = inpab_q;
    assign complete  = cmp_q;
    assign exc_over  = ovr_q;
    assign exc_under = und_q;
    assign timeout   = tmo_q;

endmodule
